// File: rtl/gate_bist_if.sv
// gate_bist_if: bundles the run handshake, the stimulus/response pins and the
// result lines of the two-input gate BIST.
`default_nettype none

interface gate_bist_if;
   logic       start;
   logic       a;
   logic       b;
   logic       c;
   logic       busy;
   logic       done;
   logic       pass;
   logic [2:0] err_count;
   logic [3:0] fail_vec;

   // master: the BIST engine; slave: the host plus the gate under test
   modport master (
      input  start,
      input  c,
      output a,
      output b,
      output busy,
      output done,
      output pass,
      output err_count,
      output fail_vec
   );

   modport slave (
      output start,
      output c,
      input  a,
      input  b,
      input  busy,
      input  done,
      input  pass,
      input  err_count,
      input  fail_vec
   );
endinterface

`default_nettype wire

// File: rtl/gate_bist.sv
// gate_bist: exhaustive BIST for a 2-input combinational gate; applies ab=00..11,
// each for HOLD_CYCLES cycles, and checks c against the TRUTH table.
`default_nettype none

module gate_bist #(
   parameter int unsigned HOLD_CYCLES = 10,       // legal range 1..255
   parameter logic [3:0]  TRUTH       = 4'b1110   // bit i = expected c for {a,b}=i
) (
   input  logic        clk,
   input  logic        rst,
   gate_bist_if.master bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [7:0] LAST_HOLD = 8'(HOLD_CYCLES - 1);
   localparam logic [1:0] LAST_IDX  = 2'd3;
   localparam logic [2:0] MAX_ERR   = 3'd4;

   logic [1:0] state;
   logic [1:0] state_nxt;

   logic [1:0] idx;
   logic [7:0] hold_cnt;
   logic [2:0] err_count;
   logic [3:0] fail_vec;
   logic [1:0] ab;

   logic       accept;
   logic       cmp_edge;
   logic       last_cmp;
   logic       mismatch;

   logic       busy;
   logic       done;
   logic       pass;

   // A start is only honoured outside RUN; while busy it is simply dropped.
   assign accept   = bus.start && (state != RUN);
   assign cmp_edge = (state == RUN) && (hold_cnt == LAST_HOLD);
   assign last_cmp = cmp_edge && (idx == LAST_IDX);
   assign mismatch = (bus.c != TRUTH[idx]);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = RUN;
         RUN:     if (last_cmp)  state_nxt = DONE;
         DONE:    if (bus.start) state_nxt = RUN;
         default:                state_nxt = IDLE;
      endcase
   end

   // ab is loaded with the next vector on the same edge idx advances, so the
   // pins always carry the vector whose response is sampled on the compare edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx       <= 2'd0;
         hold_cnt  <= 8'd0;
         err_count <= 3'd0;
         fail_vec  <= 4'd0;
         ab        <= 2'd0;
      end else if (accept) begin
         idx       <= 2'd0;
         hold_cnt  <= 8'd0;
         err_count <= 3'd0;
         fail_vec  <= 4'd0;
         ab        <= 2'd0;
      end else if (cmp_edge) begin
         hold_cnt <= 8'd0;
         idx      <= idx + 2'd1;
         ab       <= last_cmp ? 2'd0 : (idx + 2'd1);
         if (mismatch) begin
            fail_vec[idx] <= 1'b1;
            if (err_count != MAX_ERR) begin
               err_count <= err_count + 3'd1;
            end
         end
      end else if (state == RUN) begin
         hold_cnt <= hold_cnt + 8'd1;
      end
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      pass = 1'b0;
      case (state)
         RUN:  busy = 1'b1;
         DONE: begin
            done = 1'b1;
            pass = (err_count == 3'd0);
         end
         default: ;
      endcase
   end

   assign bus.a         = ab[1];
   assign bus.b         = ab[0];
   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.pass      = pass;
   assign bus.err_count = err_count;
   assign bus.fail_vec  = fail_vec;

endmodule

`default_nettype wire

// File: tb/tb_gate_bist.sv
// tb_gate_bist: directed checks of gate_bist with HOLD_CYCLES=10 and HOLD_CYCLES=1
// against OR, stuck-at-0 and AND gates modelled in the bench.
`timescale 1ns/1ps
`default_nettype none

module tb_gate_bist;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   mode10   = 0;   // 0: OR, 1: stuck-at-0, 2: AND
   int   mode1    = 2;

   always #5 clk = ~clk;

   gate_bist_if bus10 ();
   gate_bist_if bus1 ();

   function automatic logic gate_model(input int m, input logic a, input logic b);
      case (m)
         0:       return a | b;
         1:       return 1'b0;
         default: return a & b;
      endcase
   endfunction

   assign bus10.c = gate_model(mode10, bus10.a, bus10.b);
   assign bus1.c  = gate_model(mode1, bus1.a, bus1.b);

   gate_bist #(.HOLD_CYCLES(10), .TRUTH(4'b1110)) dut10 (
      .clk (clk),
      .rst (rst),
      .bus (bus10.master)
   );

   gate_bist #(.HOLD_CYCLES(1), .TRUTH(4'b1110)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1.master)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_run(input int which, input string tag, input logic [1:0] ab,
                          input logic busy, input logic done);
      if (which == 10) begin
         check_eq({tag, ".ab"},   {30'd0, bus10.a, bus10.b}, {30'd0, ab});
         check_eq({tag, ".busy"}, {31'd0, bus10.busy},       {31'd0, busy});
         check_eq({tag, ".done"}, {31'd0, bus10.done},       {31'd0, done});
      end else begin
         check_eq({tag, ".ab"},   {30'd0, bus1.a, bus1.b},   {30'd0, ab});
         check_eq({tag, ".busy"}, {31'd0, bus1.busy},        {31'd0, busy});
         check_eq({tag, ".done"}, {31'd0, bus1.done},        {31'd0, done});
      end
   endtask

   task automatic chk_res(input int which, input string tag, input logic pass,
                          input logic [2:0] err, input logic [3:0] fail);
      if (which == 10) begin
         check_eq({tag, ".pass"}, {31'd0, bus10.pass},      {31'd0, pass});
         check_eq({tag, ".err"},  {29'd0, bus10.err_count}, {29'd0, err});
         check_eq({tag, ".fail"}, {28'd0, bus10.fail_vec},  {28'd0, fail});
      end else begin
         check_eq({tag, ".pass"}, {31'd0, bus1.pass},       {31'd0, pass});
         check_eq({tag, ".err"},  {29'd0, bus1.err_count},  {29'd0, err});
         check_eq({tag, ".fail"}, {28'd0, bus1.fail_vec},   {28'd0, fail});
      end
   endtask

   // Called at a negedge; returns at the negedge right after the accepting edge.
   task automatic pulse10();
      bus10.start = 1'b1;
      @(posedge clk);
      #1 bus10.start = 1'b0;
      @(negedge clk);
   endtask

   // Offset n = negedge after accepting edge t + n. restart_at < 0 disables the extra pulse.
   task automatic run10(input string tag, input int restart_at, input logic pass,
                        input logic [2:0] err, input logic [3:0] fail);
      pulse10();
      chk_res(10, {tag, "@0"}, 1'b0, 3'd0, 4'd0);
      for (int n = 0; n <= 40; n++) begin
         if (n > 0) @(negedge clk);
         if (n == 0 || n == 9 || n == 10 || n == 19 || n == 20 ||
             n == 26 || n == 29 || n == 30 || n == 39) begin
            chk_run(10, $sformatf("%s@%0d", tag, n), 2'(n / 10), 1'b1, 1'b0);
         end
         if (n == 40) begin
            chk_run(10, {tag, "@40"}, 2'b00, 1'b0, 1'b1);
            chk_res(10, {tag, "@40"}, pass, err, fail);
         end
         bus10.start = (n == restart_at);
      end
      bus10.start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      bus10.start = 1'b0;
      bus1.start  = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_run(10, "reset10", 2'b00, 1'b0, 1'b0);
      chk_res(10, "reset10", 1'b0, 3'd0, 4'd0);
      chk_run(1, "reset1", 2'b00, 1'b0, 1'b0);
      chk_res(1, "reset1", 1'b0, 3'd0, 4'd0);
      rst = 1'b0;
      @(negedge clk);

      mode10 = 0;
      run10("or", -1, 1'b1, 3'd0, 4'b0000);
      mode10 = 1;
      run10("stuck0", -1, 1'b0, 3'd3, 4'b1110);
      mode10 = 2;
      run10("and", -1, 1'b0, 3'd2, 4'b0110);
      mode10 = 0;
      run10("restart_ignored", 25, 1'b1, 3'd0, 4'b0000);

      // Abort a stuck-at-0 run after vector 1 has already mismatched.
      mode10 = 1;
      pulse10();
      repeat (25) @(negedge clk);
      chk_run(10, "prerst", 2'b10, 1'b1, 1'b0);
      chk_res(10, "prerst", 1'b0, 3'd1, 4'b0010);
      rst = 1'b1;
      @(negedge clk);
      chk_run(10, "midrst", 2'b00, 1'b0, 1'b0);
      chk_res(10, "midrst", 1'b0, 3'd0, 4'd0);
      rst = 1'b0;
      @(negedge clk);
      mode10 = 0;
      run10("after_rst", -1, 1'b1, 3'd0, 4'b0000);

      // HOLD_CYCLES=1: AND run, then restart in the cycle done rises with an OR gate.
      mode1 = 2;
      bus1.start = 1'b1;
      @(posedge clk);
      #1 bus1.start = 1'b0;
      @(negedge clk);
      chk_run(1, "h1@0", 2'b00, 1'b1, 1'b0);
      @(negedge clk);
      chk_run(1, "h1@1", 2'b01, 1'b1, 1'b0);
      @(negedge clk);
      chk_run(1, "h1@2", 2'b10, 1'b1, 1'b0);
      @(negedge clk);
      chk_run(1, "h1@3", 2'b11, 1'b1, 1'b0);
      @(negedge clk);
      chk_run(1, "h1@4", 2'b00, 1'b0, 1'b1);
      chk_res(1, "h1@4", 1'b0, 3'd2, 4'b0110);
      mode1 = 0;
      bus1.start = 1'b1;
      @(posedge clk);
      #1 bus1.start = 1'b0;
      @(negedge clk);
      chk_run(1, "h1r@0", 2'b00, 1'b1, 1'b0);
      chk_res(1, "h1r@0", 1'b0, 3'd0, 4'd0);
      repeat (3) @(negedge clk);
      chk_run(1, "h1r@3", 2'b11, 1'b1, 1'b0);
      @(negedge clk);
      chk_run(1, "h1r@4", 2'b00, 1'b0, 1'b1);
      chk_res(1, "h1r@4", 1'b1, 3'd0, 4'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
